fc2_accumulator: RTL
====================

FC2_ACCUMULATOR -- requirements
Module: fc2_accumulator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, IEEE-754 single-precision word width.
REQ-002 Parameter NUM_INPUTS, default 84, product beats per frame (FC2 fan-in).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 prod_in  input  10*DATA_WIDTH  ten FP products from the FC2 multiplier bank; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  1  prod_in holds a valid beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 bias_in  input  10*DATA_WIDTH  per-lane FP bias, same lane packing, stable for the whole frame.
REQ-010 sum_out  output  10*DATA_WIDTH  per-lane FP result (sum of products + bias).
REQ-011 class_idx  output  4  index 0-9 of the maximum sum_out lane.
REQ-012 out_valid  output  1  sum_out and class_idx are valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 The block SHALL instantiate ten FP_Adder units (ports FP_in1, FP_in2, FP_out); operand 1 = acc[i], operand 2 = prod_in lane i in ACCUM, bias_in lane i in BIAS.
REQ-015 States SHALL be ACCUM, BIAS, ARGMAX, DONE.
REQ-016 ACCUM: in_ready=1; on in_valid, acc[i] <= acc[i]+prod_i and beat counter increments; the beat with counter==NUM_INPUTS-1 moves the state to BIAS.
REQ-017 A cycle with in_valid=0 in ACCUM SHALL leave acc and counter unchanged.
REQ-018 in_ready SHALL be 0 in BIAS, ARGMAX and DONE; in_valid in those states SHALL be ignored.
REQ-019 BIAS: exactly one cycle; acc[i] <= acc[i]+bias_i; best_idx <= 0, scan <= 1; next state ARGMAX.
REQ-020 ARGMAX: one lane per cycle; if acc[scan] > acc[best_idx], then best_idx <= scan; scan increments; after lane 9 is compared, next state DONE (9 cycles total).
REQ-021 Comparison: differing signs, positive is larger; both positive, larger unsigned magnitude bits are larger; both negative, smaller magnitude bits are larger; +0 and -0 are equal; NaN has no special handling.
REQ-022 Ties SHALL keep the lower index.
REQ-023 DONE: out_valid=1, sum_out=acc, class_idx=best_idx, all held stable until out_ready=1.
REQ-024 On out_valid and out_ready in DONE: acc <= +0.0 (all lanes), counter <= 0, next state ACCUM; out_valid drops the next cycle.
REQ-025 Latency: if the final beat is accepted at edge k, out_valid SHALL rise after edge k+11.
REQ-026 Overflow, rounding and denormals SHALL follow FP_Adder; there is no saturation logic.
REQ-027 sum_out SHALL be driven from acc in all states; it is meaningful only when out_valid=1.

Reset
REQ-028 When rst_n=0 at a rising edge: state=ACCUM, acc all 32'h00000000, counter=0, best_idx=0, class_idx=0, out_valid=0; in_ready=1 from the next cycle.
REQ-029 Reset mid-frame or in DONE SHALL discard partial sums and the pending result without emitting them.

Verification
REQ-030 All lanes 0x3F800000 (1.0) for 84 beats, bias 0 -> every lane 0x42A80000 (84.0), class_idx=0 (tie), out_valid 11 cycles after the last beat.
REQ-031 Lane 7 = 1.0, other lanes 0x3F000000 (0.5) -> lane 7 0x42A80000, others 0x42280000, class_idx=7; repeat with random in_valid gaps and expect identical results.
REQ-032 All lanes 0xBF800000 (-1.0), lane 3 = 0xBF000000 (-0.5) -> lane 3 0xC2280000, others 0xC2A80000, class_idx=3.
REQ-033 Products all 0, bias lane i = float(i) -> lane 9 = 0x41100000, class_idx=9.
REQ-034 Hold out_ready=0 for 20 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no beats counted; then 84 new beats of 1.0 -> 84.0.
REQ-035 rst_n low for 1 cycle after 40 beats of 1.0, then 84 beats of 1.0 -> 0x42A80000 (not 124.0), and out_valid never asserts before the reset.

Source files
------------

// File: rtl/fc2_accumulator.sv
// fc2_accumulator: accumulates FC2 product beats per lane, adds bias, then scans for the argmax class.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   prod_in, in_valid/in_ready ten packed FP32 products per beat, accepted only while accumulating
//   bias_in                    ten packed FP32 biases, held stable for the frame
//   sum_out                    per-lane accumulator contents (meaningful while out_valid)
//   class_idx                  lane index of the largest sum
//   out_valid/out_ready        result handshake; result holds until accepted

// FP_Adder: combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Ports: FP_in1, FP_in2 operands; FP_out sum.
module FP_Adder (
    input  logic [31:0] FP_in1,
    input  logic [31:0] FP_in2,
    output logic [31:0] FP_out
);
    logic        swap, up;
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [26:0] ax, ay, ym;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] r;
    always_comb begin
        // x always carries the larger magnitude so the subtraction never goes negative
        swap = FP_in2[30:0] > FP_in1[30:0];
        x = swap ? FP_in2 : FP_in1;
        y = swap ? FP_in1 : FP_in2;
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        d = ex - ey;
        // mantissas carry three extra bits: guard, round, sticky
        ax = {x[30:23] != 8'd0, x[22:0], 3'b000};
        ym = {y[30:23] != 8'd0, y[22:0], 3'b000};
        ay = ym >> d;
        ay[0] = ay[0] | (|(ym & ~({27{1'b1}} << d)));
        e = {2'b00, ex};
        s = (x[31] == y[31]) ? {1'b0, ax} + {1'b0, ay} : {1'b0, ax} - {1'b0, ay};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end
        // normalise left, stopping at the denormal exponent
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && e > 10'd1) begin
                s = s << 1;
                e = e - 10'd1;
            end
        end
        up = s[2] & (s[1] | s[0] | s[3]);
        r = {1'b0, s[26:3]} + {24'd0, up};
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'd1;
        end
        // exact cancellation yields +0
        FP_out = {x[31] & (r != 25'd0), r[23] ? e[7:0] : 8'd0, r[22:0]};
        if (e >= 10'd255)
            FP_out = {x[31], 8'hFF, 23'd0};
        if (x[30:23] == 8'hFF)
            FP_out = x;
    end
endmodule

module fc2_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 84
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [10*DATA_WIDTH-1:0] prod_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [10*DATA_WIDTH-1:0] bias_in,
    output logic [10*DATA_WIDTH-1:0] sum_out,
    output logic [3:0]               class_idx,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int CW = $clog2(NUM_INPUTS + 1);

    typedef enum logic [1:0] {ACCUM, BIAS, ARGMAX, DONE} state_t;

    state_t                        state, state_nx;
    logic [9:0][DATA_WIDTH-1:0]    acc, add_out;
    logic [CW-1:0]                 cnt;
    logic [3:0]                    scan, best_idx;
    logic                          beat, last_beat, take;

    // signed-magnitude ordering: +0 and -0 compare equal
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (a[DATA_WIDTH-2:0] == '0 && b[DATA_WIDTH-2:0] == '0)
            return 1'b0;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            return !a[DATA_WIDTH-1];
        return a[DATA_WIDTH-1] ? (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0])
                               : (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]);
    endfunction

    for (genvar g = 0; g < 10; g++) begin : g_add
        FP_Adder u_add (
            .FP_in1(acc[g]),
            .FP_in2(state == BIAS ? bias_in[g*DATA_WIDTH +: DATA_WIDTH] : prod_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .FP_out(add_out[g])
        );
    end

    assign in_ready  = state == ACCUM;
    assign beat      = in_ready && in_valid;
    assign last_beat = cnt == CW'(NUM_INPUTS - 1);
    assign take      = state == DONE && out_valid && out_ready;
    assign sum_out   = acc;
    assign class_idx = best_idx;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ACCUM;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:  state_nx = (beat && last_beat) ? BIAS : ACCUM;
            BIAS:   state_nx = ARGMAX;
            ARGMAX: state_nx = (scan == 4'd9) ? DONE : ARGMAX;
            DONE:   state_nx = take ? ACCUM : DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            scan      <= '0;
            best_idx  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (beat) begin
                acc <= add_out;
                cnt <= last_beat ? '0 : cnt + CW'(1);
            end
            if (state == BIAS) begin
                acc      <= add_out;
                best_idx <= 4'd0;
                scan     <= 4'd1;
            end
            if (state == ARGMAX) begin
                if (gt(acc[scan], acc[best_idx]))
                    best_idx <= scan;
                scan <= scan + 4'd1;
            end
            // registered a cycle after entering DONE, giving the 11-edge beat-to-result latency
            out_valid <= state == DONE && !take;
            if (take) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
endmodule
